// File: rtl/drsstc_pkg.sv
// drsstc_pkg: shared types, defaults and timer-width helper for the gate driver
package drsstc_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DEAD, ST_ON_A, ST_ON_B} state_t;
  typedef enum logic [1:0] {TGT_STOP, TGT_A, TGT_B} tgt_t;
  localparam int DEAD_DEF = 5;
  localparam int ON_MAX_DEF = 20;
  function automatic int tmr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gate_drv_if.sv
// gate_drv_if: bridge-driver signal bundle
// en/fb come from the controller; gate_a/gate_b/busy/fb_lost return from the driver
interface gate_drv_if;
  logic en;
  logic fb;
  logic gate_a;
  logic gate_b;
  logic busy;
  logic fb_lost;
  modport master (output en, fb, input gate_a, gate_b, busy, fb_lost);
  modport slave (input en, fb, output gate_a, gate_b, busy, fb_lost);
endinterface

// File: rtl/dead_tmr.sv
// dead_tmr: loadable down-counter that parks at zero, with zero flag
// ports: clk, rst (async, high), load, val (reload value), zero (count is 0)
module dead_tmr import drsstc_pkg::*; #(
  parameter int MAX = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [tmr_w(MAX)-1:0]   val,
  output logic                    zero
);
  logic [tmr_w(MAX)-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/gate_drv.sv
// gate_drv: DRSSTC half-bridge gate driver with feedback commutation and dead time
// ports: clk, rst (async, high), bus (gate_drv_if.slave: en, fb in; gate_a, gate_b, busy, fb_lost out)
// option: GATE_DRV_WATCHDOG_EN adds an on-time watchdog that forces commutation and pulses fb_lost
module gate_drv import drsstc_pkg::*; #(
  parameter int DEAD   = DEAD_DEF,
  parameter int ON_MAX = ON_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  gate_drv_if.slave   bus
);
  localparam int DW = tmr_w(DEAD);
  if (DEAD < 1 || DEAD > 255 || ON_MAX < 2 || ON_MAX > 1023) begin : g_bad_param
    $error("gate_drv: DEAD or ON_MAX out of range");
  end
  state_t state, nxt;
  tgt_t tgt, nxt_tgt;
  logic dz, trip, gate_a, gate_b;
  dead_tmr #(.MAX(DEAD)) u_dead (
    .clk(clk), .rst(rst),
    .load(nxt == ST_DEAD && state != ST_DEAD),
    .val(DW'(DEAD - 1)),
    .zero(dz)
  );
`ifdef GATE_DRV_WATCHDOG_EN
  localparam int OW = tmr_w(ON_MAX);
  logic lost;
  dead_tmr #(.MAX(ON_MAX)) u_on (
    .clk(clk), .rst(rst),
    .load(state == ST_DEAD && (nxt == ST_ON_A || nxt == ST_ON_B)),
    .val(OW'(ON_MAX - 1)),
    .zero(trip)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) lost <= 1'b0;
    else lost <= bus.en && trip && ((state == ST_ON_A && bus.fb) || (state == ST_ON_B && !bus.fb));
  assign bus.fb_lost = lost;
`else
  assign trip = 1'b0;
  assign bus.fb_lost = 1'b0;
`endif
  // en=0 wins over fb or watchdog: the exit target becomes STOP
  always_comb begin
    nxt = state;
    nxt_tgt = tgt;
    case (state)
      ST_IDLE: if (bus.en) begin
        nxt = ST_DEAD;
        nxt_tgt = bus.fb ? TGT_A : TGT_B;
      end
      ST_DEAD: if (dz) nxt = (tgt == TGT_STOP || !bus.en) ? ST_IDLE : (tgt == TGT_A ? ST_ON_A : ST_ON_B);
      ST_ON_A: if (!bus.en || !bus.fb || trip) begin
        nxt = ST_DEAD;
        nxt_tgt = bus.en ? TGT_B : TGT_STOP;
      end
      ST_ON_B: if (!bus.en || bus.fb || trip) begin
        nxt = ST_DEAD;
        nxt_tgt = bus.en ? TGT_A : TGT_STOP;
      end
      default: nxt = ST_IDLE;
    endcase
  end
  // gates decode the next state so they switch on the same edge as the state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      tgt <= TGT_STOP;
      gate_a <= 1'b0;
      gate_b <= 1'b0;
    end else begin
      state <= nxt;
      tgt <= nxt_tgt;
      gate_a <= nxt == ST_ON_A;
      gate_b <= nxt == ST_ON_B;
    end
  assign bus.gate_a = gate_a;
  assign bus.gate_b = gate_b;
  assign bus.busy = state != ST_IDLE;
endmodule

// File: tb/tb_gate_drv.sv
// tb_gate_drv: directed + random check of gate_drv against a cycle-count reference model
module tb_gate_drv;
  localparam int DEAD = 5;
  localparam int ON_MAX = 20;
`ifdef GATE_DRV_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  gate_drv_if bus ();
  gate_drv #(.DEAD(DEAD), .ON_MAX(ON_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_assert = 0;
  int n_fail = 0;
  bit m_a, m_b, m_lost;
  int m_dead, m_goal, m_on;
  int last_hi = 0;
  int low_run = 0;
  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_a = 0; m_b = 0; m_lost = 0; m_dead = 0; m_goal = 0; m_on = 0;
  endtask
  task automatic start_dead(input int goal);
    m_a = 0; m_b = 0; m_dead = DEAD; m_goal = goal;
  endtask
  // goal: 0 = stop, 1 = leg A, 2 = leg B; m_dead counts remaining low cycles
  task automatic model_step();
    m_lost = 0;
    if (rst) model_reset();
    else if (m_a || m_b) begin
      m_on++;
      if (!bus.en) start_dead(0);
      else if (m_a ? !bus.fb : bus.fb) start_dead(m_a ? 2 : 1);
      else if (WD && m_on == ON_MAX) begin
        m_lost = 1;
        start_dead(m_a ? 2 : 1);
      end
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0 && m_goal != 0 && bus.en) begin
        m_a = m_goal == 1; m_b = m_goal == 2; m_on = 0;
      end
    end else if (bus.en) start_dead(bus.fb ? 1 : 2);
  endtask
  task automatic check_all();
    int cur;
    chk("gate_a", bus.gate_a, m_a);
    chk("gate_b", bus.gate_b, m_b);
    chk("busy", bus.busy, m_a || m_b || m_dead > 0);
    chk("fb_lost", bus.fb_lost, m_lost);
    chk("no_overlap", bus.gate_a & bus.gate_b, 1'b0);
    if (bus.gate_a || bus.gate_b) begin
      cur = bus.gate_a ? 1 : 2;
      if (last_hi != 0 && last_hi != cur) chk("dead_gap", low_run >= DEAD, 1'b1);
      last_hi = cur;
      low_run = 0;
    end else low_run++;
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
    end
  endtask
  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.fb = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;
    bus.en = 1'b1; bus.fb = 1'b1;
    cyc(10);
    bus.fb = 1'b0;
    cyc(10);
    bus.en = 1'b0; bus.fb = 1'b1;
    cyc(8);
    chk("stop_idle_busy", bus.busy, 1'b0);
    bus.en = 1'b1; bus.fb = 1'b1;
    cyc(70);
    bus.en = 1'b0;
    cyc(12);
    bus.en = 1'b1; bus.fb = 1'b1;
    cyc(8);
    chk("pre_rst_gate_a", bus.gate_a, 1'b1);
    #2 rst = 1'b1;
    #1 model_reset();
    chk("async_gate_a", bus.gate_a, 1'b0);
    chk("async_busy", bus.busy, 1'b0);
    @(negedge clk);
    cyc(2);
    rst = 1'b0;
    cyc(10);
    bus.fb = 1'b0;
    cyc(10);
    for (int i = 0; i < 4000; i++) begin
      bus.en = $urandom_range(0, 15) != 0;
      if ($urandom_range(0, 9) == 0) bus.fb = ~bus.fb;
      cyc(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
